// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM subordinate: byte-lane writes, programmable wait states, two-cycle ERROR.
// Define AHB_SUB_BURST_CHECK_EN to check SEQ beat addresses against the burst type.
module ahb_sram_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 512,
  parameter int WAIT_WRITE   = 0,
  parameter int WAIT_READ    = 0
) (
  input  logic                  i_hclk,
  input  logic                  i_hreset,
  input  logic                  i_hsel,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [2:0]            i_hburst,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hreadyin,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);
  localparam int IDX_W = $clog2(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BYTE_LIMIT = ADDR_WIDTH'(4 * MEMORY_DEPTH);
  localparam logic [3:0] WW = 4'(WAIT_WRITE);
  localparam logic [3:0] WR = 4'(WAIT_READ);

  typedef enum logic [1:0] {ST_READY, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              size_q;
  logic                    write_q;
  logic                    dp_valid;
  logic [DATA_WIDTH-1:0]   mem [MEMORY_DEPTH];

  logic                    accept, illegal, burst_err, wr_en;
  logic [3:0]              wait_sel, be;
  logic [IDX_W-1:0]        rd_idx, wr_idx;
  logic [DATA_WIDTH-1:0]   fwd_word;

  assign accept   = i_hsel & i_hreadyin & i_htrans[1];
  assign wait_sel = i_hwrite ? WW : WR;
  assign rd_idx   = i_haddr[IDX_W+1:2];
  assign wr_idx   = addr_q[IDX_W+1:2];
  assign illegal  = (i_haddr >= BYTE_LIMIT) | (i_hsize > 3'd2)
                  | ((i_hsize == 3'd1) & i_haddr[0])
                  | ((i_hsize == 3'd2) & (|i_haddr[1:0]))
                  | burst_err;
  // A legal write lands in memory at the edge its data phase completes.
  assign wr_en    = dp_valid & write_q & o_hreadyout;

`ifdef AHB_SUB_BURST_CHECK_EN
  logic [2:0]            burst_q;
  logic                  seq_live;
  logic [ADDR_WIDTH-1:0] step_sz, nxt_incr, wrap_mask, exp_addr;

  always_comb begin
    step_sz  = ADDR_WIDTH'(1) << size_q;
    nxt_incr = addr_q + step_sz;
    case (burst_q)
      3'd2:    wrap_mask = (step_sz << 2) - ADDR_WIDTH'(1);
      3'd4:    wrap_mask = (step_sz << 3) - ADDR_WIDTH'(1);
      3'd6:    wrap_mask = (step_sz << 4) - ADDR_WIDTH'(1);
      default: wrap_mask = '0;
    endcase
    exp_addr  = (wrap_mask == '0) ? nxt_incr
                                  : ((addr_q & ~wrap_mask) | (nxt_incr & wrap_mask));
    burst_err = (i_htrans == 2'b11) & (~seq_live | (i_haddr != exp_addr));
  end

  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      burst_q  <= '0;
      seq_live <= 1'b0;
    end else if (o_hreadyout && i_hsel && i_hreadyin) begin
      if (i_htrans[1]) begin
        burst_q  <= i_hburst;
        seq_live <= ~illegal;
      end else if (i_htrans == 2'b00) begin
        seq_live <= 1'b0;
      end
    end
  end
`else
  logic unused_bits;
  assign burst_err   = 1'b0;
  assign unused_bits = ^{i_hburst, i_htrans[0], addr_q, size_q};
`endif

  always_comb begin
    case (size_q[1:0])
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Read accepted on the same edge a write completes sees the merged word.
  always_comb begin
    fwd_word = mem[rd_idx];
    for (int b = 0; b < 4; b++)
      if (wr_en && be[b] && (wr_idx == rd_idx)) fwd_word[8*b +: 8] = i_hwdata[8*b +: 8];
  end

  always_comb begin
    o_hreadyout = 1'b1;
    o_hresp     = 1'b0;
    case (state)
      ST_WAIT: o_hreadyout = (cnt == 4'd0);
      ST_ERR1: begin o_hreadyout = 1'b0; o_hresp = 1'b1; end
      ST_ERR2: o_hresp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_WAIT: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
      ST_ERR1: state_nxt = ST_ERR2;
      default: ;
    endcase
    if (o_hreadyout) begin
      state_nxt = ST_READY;
      cnt_nxt   = 4'd0;
      if (accept) begin
        if (illegal) state_nxt = ST_ERR1;
        else if (wait_sel != 4'd0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = wait_sel;
        end
      end
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      state    <= ST_READY;
      cnt      <= 4'd0;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      dp_valid <= 1'b0;
      o_hrdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (o_hreadyout) begin
        dp_valid <= accept & ~illegal;
        if (accept) begin
          addr_q  <= i_haddr;
          size_q  <= i_hsize;
          write_q <= i_hwrite;
        end
      end
      // Read data appears in the single cycle where hreadyout is high.
      if (o_hreadyout && accept && !illegal && !i_hwrite && (wait_sel == 4'd0))
        o_hrdata <= fwd_word;
      else if ((state == ST_WAIT) && (cnt == 4'd1) && !write_q)
        o_hrdata <= mem[wr_idx];
    end
  end

  always_ff @(posedge i_hclk) begin
    for (int b = 0; b < 4; b++)
      if (wr_en && be[b]) mem[wr_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
  end

endmodule
